square_reader: RTL
==================

# square_reader

Rectangle scanner for the 1-bit pixel framebuffer. It reads back the (SIZE+1)×(SIZE+1) pixel region that the square drawer writes, with inclusive corners (x0,y0) through (x0+SIZE,y0+SIZE). It issues one framebuffer read per cycle in raster order and counts the lit pixels. The count and an all-lit flag are reported through the same level start/done handshake the drawer uses, so the block can verify or hit-test drawn squares.

## Interface
- SIZE, default 10: square edge offset. The region is SIZE+1 pixels per side. Legal range is 0..254.
- WIDTH, default 640: screen width. Columns at or above WIDTH are off-screen.
- HEIGHT, default 480: screen height. Rows at or above HEIGHT are off-screen.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low. Asserting it (0) clears all state immediately.
- start  in  1  level request. Sampled only in idle and finish.
- x0  in  11  left column. Latched on the edge leaving idle.
- y0  in  11  top row. Latched on the edge leaving idle.
- rd_en  out  1  framebuffer read strobe.
- rd_x  out  11  read column.
- rd_y  out  11  read row.
- rd_data  in  1  pixel value. Valid exactly one cycle after the rd_en cycle (synchronous RAM).
- count  out  16  number of lit pixels read in the last scan.
- all_set  out  1  high when count equals (SIZE+1)².
- done  out  1  high while in finish.

## Operation
- States: idle, scan, drain, finish.
- idle:
  - If start=1, go to scan.
  - On that edge, latch cx=x0, cy=y0, xs=x0, ye=y0+SIZE, and clear count to 0.
  - Otherwise stay in idle.
- scan:
  - Drive rd_x=cx[10:0] and rd_y=cy[10:0].
  - rd_en=1 only if cx<WIDTH and cy<HEIGHT.
  - Advance raster each cycle:
    - if cx==xs+SIZE, then cx←xs and cy←cy+1;
    - else cx←cx+1.
  - When cx==xs+SIZE and cy==ye, go to drain.
- drain: rd_en=0. This cycle exists only to accumulate the last read's data. Next state is finish.
- finish: done=1. Stay while start=1; go to idle when start=0.
- Accumulation:
  - A registered copy rd_en_q tracks rd_en.
  - On each edge with rd_en_q=1, count←count+rd_data.
  - Off-screen positions are not read and add nothing.
- Arithmetic:
  - cx, cy, xs and ye are 12 bits internally, so x0+SIZE up to 2047+254 does not wrap.
  - Any internal value ≥2048 is off-screen.
- all_set is combinational: count==(SIZE+1)².
- count and all_set hold their values from finish through idle. They clear only on the next idle→scan edge.
- start deasserted during scan or drain is ignored; the scan always completes.
- x0/y0 changes after the latching edge are ignored.

## Timing
- Reset values: state=idle, rd_en=0, rd_x=0, rd_y=0, count=0, all_set=0 (SIZE≥0), done=0, rd_en_q=0.
- Reset is asynchronous: outputs take reset values without waiting for a clock edge. Reset mid-scan discards the scan.
- Let E0 be the edge taking idle→scan and N=(SIZE+1)². Then:
  - scan cycles run E0..E0+N−1;
  - drain occupies the cycle after E0+N;
  - done rises after edge E0+N+1, with the final count already valid at that point.
- The first read address (x0,y0) appears in the cycle after E0.
- Throughput is one read per cycle, with no stalls.
- A new scan can start at the earliest two edges after done rises: finish→idle needs start=0 at one edge, then start=1 at the next.

## Test plan
1. All-ones memory model, reset released, x0=y0=20, start held high.
   - Expect rd_(x,y) to step (20,20),(21,20)…(30,20),(20,21)…(30,30).
   - Expect done high after E0+122, count=121, all_set=1.
2. Memory with only the 11×11 square at (20,20) lit, scan at x0=y0=25.
   - Expect count=36, all_set=0.
   - Expect a second scan at x0=y0=0 to return count=0.
3. Clipping: all-ones memory, x0=635, y0=475.
   - Expect rd_en high only for cx≤639 and cy≤479 (25 reads).
   - Expect count=25, all_set=0, done timing unchanged (E0+122).
4. Handshake:
   - Hold start high 5 cycles past done: done stays 1.
   - Drop start: idle next edge, done=0, count still 121.
   - Raise start: count clears to 0 on E0.
5. Assert reset low mid-scan, between clock edges.
   - Expect rd_en, done and count all 0 immediately.
   - After release with start=0, expect the block to stay in idle.
6. Change x0/y0 and drop start during scan.
   - Expect the address sequence and final count to be unaffected, and done to still assert at E0+N+1.

Source files
------------

// File: rtl/square_reader.sv
// Raster scanner over a (SIZE+1)x(SIZE+1) framebuffer region. It issues one read per cycle,
// counts the lit pixels and reports the count through a level start/done handshake.
module square_reader #(
  parameter int SIZE   = 10,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  output logic        rd_en,
  output logic [10:0] rd_x,
  output logic [10:0] rd_y,
  input  logic        rd_data,
  output logic [15:0] count,
  output logic        all_set,
  output logic        done
);

  localparam logic [11:0] SPAN = 12'(SIZE);
  localparam logic [15:0] AREA = 16'((SIZE + 1) * (SIZE + 1));

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t      state;
  logic [11:0] cx, cy, xs, ye;
  logic        rd_en_q;
  logic        row_end, last_pos;
  logic [11:0] nx, ny;

  function automatic logic on_screen(input logic [11:0] x, input logic [11:0] y);
    return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  endfunction

  always_comb begin
    row_end  = (cx == xs + SPAN);
    last_pos = row_end && (cy == ye);
    nx       = row_end ? xs : cx + 12'd1;
    ny       = row_end ? cy + 12'd1 : cy;
  end

  assign all_set = (count == AREA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cx      <= '0;
      cy      <= '0;
      xs      <= '0;
      ye      <= '0;
      rd_en   <= 1'b0;
      rd_x    <= '0;
      rd_y    <= '0;
      rd_en_q <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      // read data arrives one cycle after its strobe
      rd_en_q <= rd_en;
      if (rd_en_q)
        count <= count + 16'(rd_data);

      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            cx    <= {1'b0, x0};
            cy    <= {1'b0, y0};
            xs    <= {1'b0, x0};
            ye    <= {1'b0, y0} + SPAN;
            count <= '0;
            rd_x  <= x0;
            rd_y  <= y0;
            rd_en <= on_screen({1'b0, x0}, {1'b0, y0});
          end
        end
        SCAN: begin
          if (last_pos) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            cx    <= nx;
            cy    <= ny;
            rd_x  <= nx[10:0];
            rd_y  <= ny[10:0];
            rd_en <= on_screen(nx, ny);
          end
        end
        DRAIN: begin
          state <= FINISH;
          done  <= 1'b1;
        end
        FINISH: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
